alu_exec_ctrl: RTL

Execute-stage controller that sits directly upstream of the 32-bit combinational ALU. It holds a 16 x 32 register file, accepts one register-format instruction per handshake and reads its operands. It then drives the ALU's `a`, `b` and `op` inputs from registers, captures the ALU result and writes it back to the destination register. The ALU opcode (4 bits, 16 functions) is passed through unchanged.

---
 rtl/alu_exec_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage controller: register file, operand fetch, ALU drive, write-back
// Three-phase sequencer (IDLE accept, EXEC evaluate, WB write) around an external combinational ALU.
module alu_exec_ctrl #(
  parameter int NREGS = 16,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [3:0]       instr_rd,
  input  logic [3:0]       instr_rs,
  input  logic [3:0]       instr_rt,
  input  logic             instr_imm_en,
  input  logic [IMM_W-1:0] instr_imm,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_out,
  output logic             done,
  output logic [31:0]      done_data,
  input  logic [3:0]       dbg_addr,
  output logic [31:0]      dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] rf_d [NREGS];
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [3:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;

  logic [31:0] rs_val, rt_val, imm_ext;

  // R0 is hardwired to zero on every read port.
  assign rs_val   = (instr_rs == 4'd0) ? 32'd0 : rf_q[instr_rs];
  assign rt_val   = (instr_rt == 4'd0) ? 32'd0 : rf_q[instr_rt];
  assign dbg_data = (dbg_addr == 4'd0) ? 32'd0 : rf_q[dbg_addr];
  assign imm_ext  = {{(32-IMM_W){instr_imm[IMM_W-1]}}, instr_imm};

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign done_data = result_q;

  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    result_d = result_q;
    instr_ready = (state_q == S_IDLE) && !rst;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          alu_a_d  = rs_val;
          alu_b_d  = instr_imm_en ? imm_ext : rt_val;
          alu_op_d = instr_op;
          rd_d     = instr_rd;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_out;
        state_d  = S_WB;
      end
      S_WB: begin
        done = !rst;
        if (rd_q != 4'd0) begin
          rf_d[rd_q] = result_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      rf_q[i] <= rst ? 32'd0 : rf_d[i];
    end
  end

endmodule
